// File: rtl/axil_cfg_target_regs.sv
// AXI-Lite target register bank behind the config-controller bus.
// The write channel has no B response.
// Ports:
//   axi_clk, axi_reset_n   clock and async active-low reset
//   cc_enable              target select; new handshakes are gated by it
//   axi_aw*, axi_w*        write address/data channels, accepted independently
//   axi_ar*, axi_r*        read channel; rdata held until rready
//   status_in              sampled every cycle into STATUS
//   event_in               pulses OR-set into the sticky W1C EVENT register
//   cfg_regs               flat RW register contents, reg0 in [31:0]
//   irq                    registered |(EVENT & reg0)
module axil_cfg_target_regs #(
  parameter int unsigned pADDR_WIDTH = 15,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pNUM_REGS   = 8
) (
  input  logic                               axi_clk,
  input  logic                               axi_reset_n,
  input  logic                               cc_enable,
  input  logic                               axi_awvalid,
  input  logic [pADDR_WIDTH-1:0]             axi_awaddr,
  output logic                               axi_awready,
  input  logic                               axi_wvalid,
  input  logic [pDATA_WIDTH-1:0]             axi_wdata,
  input  logic [pDATA_WIDTH/8-1:0]           axi_wstrb,
  output logic                               axi_wready,
  input  logic                               axi_arvalid,
  input  logic [pADDR_WIDTH-1:0]             axi_araddr,
  output logic                               axi_arready,
  output logic [pDATA_WIDTH-1:0]             axi_rdata,
  output logic                               axi_rvalid,
  input  logic                               axi_rready,
  input  logic [pDATA_WIDTH-1:0]             status_in,
  input  logic [pDATA_WIDTH-1:0]             event_in,
  output logic [pDATA_WIDTH*(pNUM_REGS-2)-1:0] cfg_regs,
  output logic                               irq
);

  localparam int unsigned NumRw     = pNUM_REGS - 2;
  localparam logic [9:0]  IdxStatus = 10'(pNUM_REGS - 2);
  localparam logic [9:0]  IdxEvent  = 10'(pNUM_REGS - 1);

  typedef enum logic [1:0] {WIdle, WAddr, WData} w_state_e;
  typedef enum logic       {RIdle, RValid}       r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                   rdy_en_q;
  logic [9:0]             lat_idx_q, lat_idx_d;
  logic [pDATA_WIDTH-1:0] lat_data_q, lat_data_d;
  logic [3:0]             lat_strb_q, lat_strb_d;
  logic [pDATA_WIDTH-1:0] regs_q [NumRw];
  logic [pDATA_WIDTH-1:0] regs_d [NumRw];
  logic [pDATA_WIDTH-1:0] status_q;
  logic [pDATA_WIDTH-1:0] event_q, event_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   irq_q, irq_d;

  logic [9:0]             aw_idx, ar_idx;
  logic                   aw_hs, w_hs, ar_hs;
  logic                   commit;
  logic [9:0]             c_idx;
  logic [pDATA_WIDTH-1:0] c_data;
  logic [3:0]             c_strb;
  logic [pDATA_WIDTH-1:0] c_mask;

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{axi_awaddr[pADDR_WIDTH-1:12], axi_awaddr[1:0],
                         axi_araddr[pADDR_WIDTH-1:12], axi_araddr[1:0]};

  assign aw_idx = axi_awaddr[11:2];
  assign ar_idx = axi_araddr[11:2];

  assign axi_awready = rdy_en_q & cc_enable & (w_state_q != WAddr);
  assign axi_wready  = rdy_en_q & cc_enable & (w_state_q != WData);
  assign axi_arready = rdy_en_q & cc_enable & (r_state_q == RIdle);
  assign axi_rvalid  = (r_state_q == RValid);
  assign axi_rdata   = rdata_q;
  assign irq         = irq_q;

  assign aw_hs = axi_awvalid & axi_awready;
  assign w_hs  = axi_wvalid & axi_wready;
  assign ar_hs = axi_arvalid & axi_arready;

  // Write channel: whichever half arrives first is latched until its partner shows up.
  always_comb begin
    w_state_d  = w_state_q;
    lat_idx_d  = lat_idx_q;
    lat_data_d = lat_data_q;
    lat_strb_d = lat_strb_q;
    commit     = 1'b0;
    c_idx      = aw_idx;
    c_data     = axi_wdata;
    c_strb     = axi_wstrb;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
        end else if (aw_hs) begin
          lat_idx_d = aw_idx;
          w_state_d = WAddr;
        end else if (w_hs) begin
          lat_data_d = axi_wdata;
          lat_strb_d = axi_wstrb;
          w_state_d  = WData;
        end
      end
      WAddr: begin
        c_idx = lat_idx_q;
        if (w_hs) begin
          commit    = 1'b1;
          w_state_d = WIdle;
        end
      end
      WData: begin
        c_data = lat_data_q;
        c_strb = lat_strb_q;
        if (aw_hs) begin
          commit    = 1'b1;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  assign c_mask = {{8{c_strb[3]}}, {8{c_strb[2]}}, {8{c_strb[1]}}, {8{c_strb[0]}}};

  // Register update; writes to STATUS or unmapped indices fall through untouched.
  always_comb begin
    for (int unsigned i = 0; i < NumRw; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && (c_idx == 10'(i))) begin
        regs_d[i] = (regs_q[i] & ~c_mask) | (c_data & c_mask);
      end
    end
    // New events are ORed in after the clear so a same-cycle set wins.
    event_d = event_q;
    if (commit && (c_idx == IdxEvent)) begin
      event_d = event_q & ~(c_data & c_mask);
    end
    event_d = event_d | event_in;
    irq_d   = |(event_q & regs_q[0]);
  end

  // Read channel; the mux looks at pre-write state, so a same-cycle write is not visible.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          r_state_d = RValid;
          rdata_d   = '1;
          for (int unsigned i = 0; i < NumRw; i++) begin
            if (ar_idx == 10'(i)) rdata_d = regs_q[i];
          end
          if (ar_idx == IdxStatus) rdata_d = status_q;
          if (ar_idx == IdxEvent)  rdata_d = event_q;
        end
      end
      RValid: begin
        if (axi_rready) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NumRw; i++) begin
      cfg_regs[i*pDATA_WIDTH +: pDATA_WIDTH] = regs_q[i];
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      w_state_q  <= WIdle;
      r_state_q  <= RIdle;
      rdy_en_q   <= 1'b0;
      lat_idx_q  <= '0;
      lat_data_q <= '0;
      lat_strb_q <= '0;
      for (int unsigned i = 0; i < NumRw; i++) regs_q[i] <= '0;
      status_q   <= '0;
      event_q    <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      rdy_en_q   <= 1'b1;
      lat_idx_q  <= lat_idx_d;
      lat_data_q <= lat_data_d;
      lat_strb_q <= lat_strb_d;
      for (int unsigned i = 0; i < NumRw; i++) regs_q[i] <= regs_d[i];
      status_q   <= status_in;
      event_q    <= event_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

endmodule
